// File: rtl/music_key_event_controller_pkg.sv
// Shared constants and event record for the music-box key front end.
package music_box_pkg;

  localparam logic [4:0]  STATE_IDLE           = 5'd0;
  localparam logic [4:0]  STATE_PLAY_RECORDING = 5'd4;
  localparam logic [31:0] DEFAULT_ENABLE_MASK  = 32'h0000_0011;

  typedef struct packed {
    logic       press;
    logic [4:0] key;
  } key_event_t;

  // Width of a key index; a single key still needs one bit.
  function automatic int key_idx_w(input int num_keys);
    return (num_keys > 1) ? $clog2(num_keys) : 1;
  endfunction

endpackage

// File: rtl/music_key_event_controller_if.sv
// Event stream from the key controller to the recording logic (valid/ready).
interface music_key_event_controller_if #(
  parameter int KEY_W = 3
);
  logic             event_valid;
  logic             event_press;
  logic [KEY_W-1:0] event_key;
  logic             event_ready;

  modport master (output event_valid, event_press, event_key, input event_ready);
  modport slave  (input event_valid, event_press, event_key, output event_ready);
endinterface

// File: rtl/music_key_event_controller_debouncer.sv
// One key: two-flop synchroniser followed by a stable-count debouncer.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic db
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

  assign s = ~sync2_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/music_key_event_controller.sv
// Debounced, state-gated music keys plus a press/release event FIFO.
module music_key_event_controller
  import music_box_pkg::*;
#(
  parameter int          NUM_KEYS          = 6,
  parameter int          DEBOUNCE_CYCLES   = 500000,
  parameter int          FIFO_DEPTH        = 8,
  parameter logic [31:0] ENABLE_STATE_MASK = DEFAULT_ENABLE_MASK
) (
  input  logic                  clock_50Mhz,
  input  logic                  reset,
  input  logic [4:0]            currentState,
  input  logic [NUM_KEYS-1:0]   input_MusicKey,
  output logic [NUM_KEYS-1:0]   outputKeyPressed,
  music_key_event_controller_if.master evt,
  output logic [31:0]           debugString
);

  localparam int KEY_W = key_idx_w(NUM_KEYS);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_KEYS-1:0] db;
  logic                en;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clock_50Mhz),
      .rst   (reset),
      .key_n (input_MusicKey[g]),
      .db    (db[g])
    );
  end

  assign en               = ENABLE_STATE_MASK[currentState];
  assign outputKeyPressed = db & {NUM_KEYS{en}};

  logic [NUM_KEYS-1:0] rep_q, rep_d;
  logic [NUM_KEYS-1:0] mismatch, pick_oh;
  logic [4:0]          pick_key;
  logic                found;

  assign mismatch = outputKeyPressed ^ rep_q;
  assign found    = |mismatch;

  // Scanning downward leaves the lowest mismatched key selected.
  always_comb begin
    pick_oh  = '0;
    pick_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (mismatch[i]) begin
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_key   = 5'(i);
      end
    end
  end

  key_event_t           mem_q [FIFO_DEPTH];
  key_event_t           push_evt, head;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full, push, pop;

  assign full           = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop            = evt.event_valid & evt.event_ready;
  assign push           = found & (~full | pop);
  assign push_evt.press = |(outputKeyPressed & pick_oh);
  assign push_evt.key   = pick_key;

  always_comb begin
    rep_d    = rep_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      rep_d    = (rep_q & ~pick_oh) | (outputKeyPressed & pick_oh);
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      rep_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rep_q    <= rep_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; stale entries are never visible because outputs are gated by valid.
  always_ff @(posedge clock_50Mhz) begin
    if (push) mem_q[wr_ptr_q] <= push_evt;
  end

  assign head            = mem_q[rd_ptr_q];
  assign evt.event_valid = (count_q != '0);
  assign evt.event_press = evt.event_valid & head.press;
  assign evt.event_key   = evt.event_valid ? head.key[KEY_W-1:0] : '0;

  assign debugString = {8'(count_q), 24'(db)};

endmodule

// File: tb/tb_music_key_event_controller.sv
// Directed vector bench for music_key_event_controller (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_music_key_event_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] state;
  logic [5:0] keys_n;
  logic [5:0] out;
  logic [31:0] debug;
  int checks = 0;
  int errors = 0;

  music_key_event_controller_if #(.KEY_W(3)) evt_if ();

  music_key_event_controller #(
    .NUM_KEYS(6), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .ENABLE_STATE_MASK(32'h11)
  ) dut (
    .clock_50Mhz      (clk),
    .reset            (rst),
    .currentState     (state),
    .input_MusicKey   (keys_n),
    .outputKeyPressed (out),
    .evt              (evt_if.master),
    .debugString      (debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  keys_n;
    logic [4:0]  state;
    logic        ready;
    int          edges;
    logic [5:0]  exp_out;
    logic        exp_valid;
    logic        exp_press;
    logic [2:0]  exp_key;
    logic [31:0] exp_debug;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic [5:0] kn, input logic [4:0] st, input logic rdy,
                            input int n, input logic [5:0] o, input logic vl,
                            input logic pr, input logic [2:0] k, input logic [31:0] d);
    vec_t r;
    r.keys_n = kn; r.state = st; r.ready = rdy; r.edges = n; r.exp_out = o;
    r.exp_valid = vl; r.exp_press = pr; r.exp_key = k; r.exp_debug = d;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at a falling edge; n rising edges later we sample at the next falling edge.
  task automatic step(input int n);
    if (n == 0) #1;
    else repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [5:0] o, input logic vl,
                           input logic pr, input logic [2:0] k, input logic [31:0] d);
    check({tag, " out"}, 32'(out), 32'(o));
    check({tag, " evt"}, 32'({evt_if.event_valid, evt_if.event_press, evt_if.event_key}),
          32'({vl, pr, k}));
    check({tag, " debug"}, debug, d);
  endtask

  initial begin
    // single press, release
    v(6'h3F,0,0,2, 6'h00,0,0,0, 32'h0);
    v(6'h3B,0,0,5, 6'h00,0,0,0, 32'h0);
    v(6'h3B,0,0,1, 6'h04,0,0,0, 32'h4);
    v(6'h3B,0,0,1, 6'h04,1,1,2, 32'h01000004);
    v(6'h3B,0,1,1, 6'h04,0,0,0, 32'h4);
    v(6'h3F,0,1,5, 6'h04,0,0,0, 32'h4);
    v(6'h3F,0,1,1, 6'h00,0,0,0, 32'h0);
    v(6'h3F,0,0,1, 6'h00,1,0,2, 32'h01000000);
    v(6'h3F,0,1,1, 6'h00,0,0,0, 32'h0);
    // glitch of 3 clocks on key 1
    v(6'h3D,0,1,3, 6'h00,0,0,0, 32'h0);
    v(6'h3F,0,1,8, 6'h00,0,0,0, 32'h0);
    // keys 0,3,5 together, then drain in order
    v(6'h16,0,0,6, 6'h29,0,0,0, 32'h29);
    v(6'h16,0,0,1, 6'h29,1,1,0, 32'h01000029);
    v(6'h16,0,0,1, 6'h29,1,1,0, 32'h02000029);
    v(6'h16,0,0,1, 6'h29,1,1,0, 32'h03000029);
    v(6'h16,0,1,1, 6'h29,1,1,3, 32'h02000029);
    v(6'h16,0,1,1, 6'h29,1,1,5, 32'h01000029);
    v(6'h16,0,1,1, 6'h29,0,0,0, 32'h29);
    v(6'h3F,0,1,6, 6'h00,0,0,0, 32'h0);
    v(6'h3F,0,1,1, 6'h00,1,0,0, 32'h01000000);
    v(6'h3F,0,1,1, 6'h00,1,0,3, 32'h01000000);
    v(6'h3F,0,1,1, 6'h00,1,0,5, 32'h01000000);
    v(6'h3F,0,1,1, 6'h00,0,0,0, 32'h0);
    // keys 1,4 in state 4, then exit to state 2
    v(6'h2D,4,0,7, 6'h12,1,1,1, 32'h01000012);
    v(6'h2D,4,0,1, 6'h12,1,1,1, 32'h02000012);
    v(6'h2D,4,1,2, 6'h12,0,0,0, 32'h12);
    v(6'h2D,2,0,0, 6'h00,0,0,0, 32'h12);
    v(6'h2D,2,0,1, 6'h00,1,0,1, 32'h01000012);
    v(6'h2D,2,0,1, 6'h00,1,0,1, 32'h02000012);
    v(6'h2D,2,1,1, 6'h00,1,0,4, 32'h01000012);
    v(6'h2D,2,1,1, 6'h00,0,0,0, 32'h12);
    v(6'h3F,2,1,8, 6'h00,0,0,0, 32'h0);
    // all six under back-pressure, then drain
    v(6'h00,0,0,6, 6'h3F,0,0,0, 32'h3F);
    v(6'h00,0,0,4, 6'h3F,1,1,0, 32'h0400003F);
    v(6'h00,0,0,3, 6'h3F,1,1,0, 32'h0400003F);
    v(6'h00,0,1,1, 6'h3F,1,1,1, 32'h0400003F);
    v(6'h00,0,1,1, 6'h3F,1,1,2, 32'h0400003F);
    v(6'h00,0,1,1, 6'h3F,1,1,3, 32'h0300003F);
    v(6'h00,0,1,1, 6'h3F,1,1,4, 32'h0200003F);
    v(6'h00,0,1,1, 6'h3F,1,1,5, 32'h0100003F);
    v(6'h00,0,1,1, 6'h3F,0,0,0, 32'h3F);

    rst = 1'b1; state = 5'd0; keys_n = 6'h3F; evt_if.event_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 6'h00, 1'b0, 1'b0, 3'd0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      keys_n = vecs[i].keys_n;
      state  = vecs[i].state;
      evt_if.event_ready = vecs[i].ready;
      step(vecs[i].edges);
      check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                vecs[i].exp_press, vecs[i].exp_key, vecs[i].exp_debug);
    end

    // Reset with three release events queued and keys still held.
    state = 5'd2; evt_if.event_ready = 1'b0;
    step(3);
    check_all("pre_rst", 6'h00, 1'b1, 1'b0, 3'd0, 32'h0300003F);
    state = 5'd0;
    #2 rst = 1'b1;
    #1 check_all("async_rst", 6'h00, 1'b0, 1'b0, 3'd0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(5);
    check_all("post_rst5", 6'h00, 1'b0, 1'b0, 3'd0, 32'h0);
    step(1);
    check_all("post_rst6", 6'h3F, 1'b0, 1'b0, 3'd0, 32'h3F);
    step(1);
    check_all("post_rst7", 6'h3F, 1'b1, 1'b1, 3'd0, 32'h0100003F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
